// File: rtl/stopwatch_sysid_pkg.sv
// stopwatch_sysid_pkg: shared FSM states, word addresses and data width for the sysid checker.
package stopwatch_sysid_pkg;
    localparam int   DATA_W        = 32;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_LAT_ID,
        ST_RD_TS,
        ST_LAT_TS,
        ST_DONE
    } state_e;
endpackage

// File: rtl/stopwatch_avm_read_unit.sv
// stopwatch_avm_read_unit: single-word Avalon read handshake with stall timeout, read latency and compare.
module stopwatch_avm_read_unit
    import stopwatch_sysid_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              lat_i,
    input  logic              waitrequest_i,
    input  logic [DATA_W-1:0] readdata_i,
    input  logic [DATA_W-1:0] expected_i,
    output logic              accept_o,
    output logic              capture_o,
    output logic              timeout_o,
    output logic              match_o
);
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LOAD   = 2'(READ_LATENCY);
    logic [15:0] stall_q, stall_d;
    logic [1:0]  lat_q, lat_d;
    // stall count restarts whenever the request is absent or accepted, so each read gets a fresh budget
    always_comb begin
        accept_o  = req_i & ~waitrequest_i;
        timeout_o = req_i & waitrequest_i & (stall_q == STALL_LAST);
        capture_o = (READ_LATENCY == 0) ? accept_o : (lat_i & (lat_q == 2'd1));
        match_o   = (readdata_i == expected_i);
        stall_d   = (req_i & waitrequest_i) ? ((stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1) : 16'd0;
        lat_d     = accept_o ? LAT_LOAD : (lat_i & (lat_q != 2'd0)) ? lat_q - 2'd1 : lat_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            lat_q   <= '0;
        end else begin
            stall_q <= stall_d;
            lat_q   <= lat_d;
        end
    end
endmodule

// File: rtl/stopwatch_sysid_checker.sv
// stopwatch_sysid_checker: reads sysid ID and build timestamp, flags a bitstream/software mismatch.
module stopwatch_sysid_checker
    import stopwatch_sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1571601221,
    parameter int                READ_LATENCY   = 0,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter bit                AUTO_START     = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_match,
    output logic              ts_match,
    output logic              timeout,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value
);
    state_e            state_q, state_d;
    logic              auto_q;
    logic [DATA_W-1:0] id_q, id_d, ts_q, ts_d;
    logic              idm_q, idm_d, tsm_q, tsm_d, to_q, to_d, pass_q, pass_d;
    logic              rd_st, lat_st, is_id, enter_rd, enter_done;
    logic              accept, capture, stall_to, match;

    stopwatch_avm_read_unit #(
        .READ_LATENCY  (READ_LATENCY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rd (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .req_i        (rd_st),
        .lat_i        (lat_st),
        .waitrequest_i(avm_waitrequest),
        .readdata_i   (avm_readdata),
        .expected_i   (is_id ? EXPECTED_ID : EXPECTED_TS),
        .accept_o     (accept),
        .capture_o    (capture),
        .timeout_o    (stall_to),
        .match_o      (match)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start | auto_q) state_d = ST_RD_ID;
            ST_RD_ID:  if (stall_to) state_d = ST_DONE;
                       else if (accept) state_d = (READ_LATENCY == 0) ? ST_RD_TS : ST_LAT_ID;
            ST_LAT_ID: if (capture) state_d = ST_RD_TS;
            ST_RD_TS:  if (stall_to) state_d = ST_DONE;
                       else if (accept) state_d = (READ_LATENCY == 0) ? ST_DONE : ST_LAT_TS;
            ST_LAT_TS: if (capture) state_d = ST_DONE;
            ST_DONE:   if (start) state_d = ST_RD_ID;
            default:   state_d = ST_IDLE;
        endcase
    end

    // pass is judged on the same edge that enters DONE, so it uses the freshly captured flags
    always_comb begin
        rd_st      = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
        lat_st     = (state_q == ST_LAT_ID) || (state_q == ST_LAT_TS);
        is_id      = (state_q == ST_RD_ID) || (state_q == ST_LAT_ID);
        enter_rd   = (state_d == ST_RD_ID) && (state_q != ST_RD_ID);
        enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
        id_d       = (capture & is_id) ? avm_readdata : id_q;
        ts_d       = (capture & ~is_id) ? avm_readdata : ts_q;
        idm_d      = enter_rd ? 1'b0 : (capture & is_id) ? match : idm_q;
        tsm_d      = enter_rd ? 1'b0 : (capture & ~is_id) ? match : tsm_q;
        to_d       = enter_rd ? 1'b0 : (to_q | stall_to);
        pass_d     = enter_rd ? 1'b0 : enter_done ? (idm_d & tsm_d & ~to_d) : pass_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            auto_q  <= AUTO_START;
            id_q    <= '0;
            ts_q    <= '0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            to_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= 1'b0;
            id_q    <= id_d;
            ts_q    <= ts_d;
            idm_q   <= idm_d;
            tsm_q   <= tsm_d;
            to_q    <= to_d;
            pass_q  <= pass_d;
        end
    end

    assign avm_read    = rd_st;
    assign avm_address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign id_match    = idm_q;
    assign ts_match    = tsm_q;
    assign timeout     = to_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
endmodule

// File: tb/tb_stopwatch_sysid_checker.sv
// tb_stopwatch_sysid_checker: two checker instances (zero latency, latency 2 / timeout 10) against modelled slaves.
module tb_stopwatch_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1571601221;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    typedef struct {
        int          k;
        int          sid;
        int          sts;
        logic [31:0] iw;
        logic [31:0] tw;
        int          cyc;
        logic        p;
        logic        im;
        logic        tm;
        logic        to;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       start = '0;
    logic [1:0]       wreq, rd, addr, busy, done, pass, idm, tsm, tmo;
    logic [1:0][31:0] rdata, idv, tsv;
    int               cfg_st [2][2];
    logic [31:0]      word [2][2];
    int               sc [2];
    int               ix [2];
    int               lc [2];
    bit               pa [2];
    int               checks = 0;
    int               errors = 0;

    always #5 clock = ~clock;

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int to_of(input int k);
        return (k == 1) ? 10 : 255;
    endfunction

    stopwatch_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) u0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
        .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .id_match(idm[0]), .ts_match(tsm[0]), .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0])
    );

    stopwatch_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2), .TIMEOUT_CYCLES(10), .AUTO_START(1'b1)
    ) u1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
        .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .id_match(idm[1]), .ts_match(tsm[1]), .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1])
    );

    // slave: stalls cfg_st cycles per read, returns data only in the cycle it is due
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!busy[k]) begin
                sc[k] <= 0;
                ix[k] <= 0;
                lc[k] <= 0;
            end else if (rd[k] && wreq[k]) begin
                sc[k] <= sc[k] + 1;
            end else if (rd[k]) begin
                sc[k] <= 0;
                ix[k] <= ix[k] + 1;
                pa[k] <= addr[k];
                lc[k] <= lat_of(k);
            end else if (lc[k] > 0) begin
                lc[k] <= lc[k] - 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wreq[k]  = sc[k] < cfg_st[k][(ix[k] > 0) ? 1 : 0];
            rdata[k] = (lat_of(k) == 0) ? (rd[k] ? word[k][addr[k]] : JUNK)
                                        : ((lc[k] == 1) ? word[k][pa[k]] : JUNK);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic configure(input int k, input int sid, input int sts, input logic [31:0] iw, input logic [31:0] tw);
        cfg_st[k][0] = sid;
        cfg_st[k][1] = sts;
        word[k][0]   = iw;
        word[k][1]   = tw;
    endtask

    // outcome from the read rules: each read costs stalls+1+latency cycles unless it stalls out
    task automatic model(input int k, input int sid, input int sts, input logic [31:0] iw, input logic [31:0] tw,
                         output int cyc, output logic p, output logic im, output logic tm, output logic to,
                         output logic idc, output logic tsc);
        int l;
        int t;
        l = lat_of(k);
        t = to_of(k);
        im = 1'b0;
        tm = 1'b0;
        to = 1'b0;
        idc = sid < t;
        tsc = idc && (sts < t);
        if (!idc) begin
            cyc = t;
            to = 1'b1;
        end else begin
            im = (iw == EXP_ID);
            if (!tsc) begin
                cyc = sid + 1 + l + t;
                to = 1'b1;
            end else begin
                cyc = sid + sts + 2 * (1 + l);
                tm = (tw == EXP_TS);
            end
        end
        p = im && tm && !to;
    endtask

    task automatic wait_done(input int k, input int j0, output int j);
        j = j0;
        while (!done[k] && j < 200) begin
            @(negedge clock);
            j++;
        end
        chk($sformatf("u%0d done_seen", k), done[k], 1'b1);
    endtask

    task automatic apply(input int k, input int sid, input int sts, input logic [31:0] iw, input logic [31:0] tw,
                         output int j);
        configure(k, sid, sts, iw, tw);
        @(negedge clock) start[k] = 1'b1;
        @(negedge clock) start[k] = 1'b0;
        wait_done(k, 0, j);
    endtask

    task automatic check_reset_state(input int k);
        chk($sformatf("u%0d reset ctl", k),
            {rd[k], addr[k], busy[k], done[k], pass[k], idm[k], tsm[k], tmo[k]}, 32'd0);
        chk($sformatf("u%0d reset id_value", k), idv[k], 32'd0);
        chk($sformatf("u%0d reset ts_value", k), tsv[k], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [8];
        int          j;
        int          k;
        int          sid;
        int          sts;
        int          cyc;
        logic [31:0] iw;
        logic [31:0] tw;
        logic        p, im, tm, to, idc, tsc;
        tbl[0] = '{0, 0, 0, EXP_ID, EXP_TS + 32'd1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{0, 2, 1, EXP_ID, EXP_TS, 5, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{0, 0, 0, 32'h1, EXP_TS, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1, 1000, 0, EXP_ID, EXP_TS, 10, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1, 0, 1000, EXP_ID, EXP_TS, 13, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1, 9, 9, EXP_ID, EXP_TS, 24, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1, 10, 0, EXP_ID, EXP_TS, 10, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1, 0, 0, EXP_ID, 32'h5DAC3D45, 6, 1'b0, 1'b1, 1'b0, 1'b0};
        configure(0, 0, 0, EXP_ID, EXP_TS);
        configure(1, 3, 3, EXP_ID, EXP_TS);
        #12;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clock) reset_n = 1'b1;
        // auto-start: u0 zero-wait, u1 three stalls per read plus latency 2
        for (int n = 0; n <= 12; n++) begin
            @(negedge clock);
            if (n <= 2) begin
                chk($sformatf("u0 auto read@%0d", n), rd[0], n < 2);
                if (n < 2) chk($sformatf("u0 auto addr@%0d", n), addr[0], n == 1);
                chk($sformatf("u0 auto done@%0d", n), done[0], n == 2);
            end
            chk($sformatf("u1 auto read@%0d", n), rd[1], (n <= 3) || (n >= 6 && n <= 9));
            if (rd[1]) chk($sformatf("u1 auto addr@%0d", n), addr[1], n >= 6);
            chk($sformatf("u1 auto done@%0d", n), done[1], n == 12);
        end
        chk("u0 auto pass", pass[0], 1'b1);
        chk("u0 auto id_value", idv[0], EXP_ID);
        chk("u0 auto ts_value", tsv[0], EXP_TS);
        chk("u1 auto pass", pass[1], 1'b1);
        chk("u1 auto ts_value", tsv[1], EXP_TS);
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].k, tbl[i].sid, tbl[i].sts, tbl[i].iw, tbl[i].tw, j);
            chk($sformatf("tbl%0d cycles", i), j, tbl[i].cyc);
            chk($sformatf("tbl%0d flags", i), {pass[tbl[i].k], idm[tbl[i].k], tsm[tbl[i].k], tmo[tbl[i].k]},
                {tbl[i].p, tbl[i].im, tbl[i].tm, tbl[i].to});
            chk($sformatf("tbl%0d read_after", i), {rd[tbl[i].k], busy[tbl[i].k]}, 2'b00);
        end
        for (int n = 0; n < 40; n++) begin
            k   = int'($urandom_range(0, 1));
            sid = int'($urandom_range(0, (k == 1) ? 12 : 4));
            sts = int'($urandom_range(0, (k == 1) ? 12 : 4));
            iw  = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
            tw  = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
            model(k, sid, sts, iw, tw, cyc, p, im, tm, to, idc, tsc);
            apply(k, sid, sts, iw, tw, j);
            chk($sformatf("rnd%0d u%0d cycles", n, k), j, cyc);
            chk($sformatf("rnd%0d u%0d flags", n, k), {pass[k], idm[k], tsm[k], tmo[k]}, {p, im, tm, to});
            if (idc) chk($sformatf("rnd%0d u%0d id_value", n, k), idv[k], iw);
            if (tsc) chk($sformatf("rnd%0d u%0d ts_value", n, k), tsv[k], tw);
        end
        // start during RD_TS is ignored; start in DONE clears flags and reruns
        configure(0, 0, 5, EXP_ID, EXP_TS + 32'd7);
        @(negedge clock) start[0] = 1'b1;
        @(negedge clock) start[0] = 1'b0;
        @(negedge clock);
        chk("busy start rd_ts", {rd[0], addr[0]}, 2'b11);
        start[0] = 1'b1;
        @(negedge clock) start[0] = 1'b0;
        wait_done(0, 2, j);
        chk("busy start cycles", j, 7);
        chk("busy start flags", {pass[0], idm[0], tsm[0], tmo[0]}, 4'b0100);
        configure(0, 0, 0, EXP_ID, EXP_TS);
        @(negedge clock) start[0] = 1'b1;
        @(negedge clock) start[0] = 1'b0;
        chk("restart cleared", {done[0], pass[0], idm[0], tsm[0], tmo[0]}, 5'b00000);
        wait_done(0, 0, j);
        chk("restart cycles", j, 2);
        chk("restart pass", pass[0], 1'b1);
        // asynchronous reset while u1 is stalled in RD_TS
        configure(1, 0, 5, EXP_ID, EXP_TS);
        @(negedge clock) start[1] = 1'b1;
        @(negedge clock) start[1] = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre-reset rd_ts", {rd[1], addr[1]}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);
        wait_done(1, 0, j);
        chk("rerun u1 cycles", j, 11);
        chk("rerun u1 pass", pass[1], 1'b1);
        chk("rerun u0 pass", {done[0], pass[0]}, 2'b11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
